// File: rtl/pe_mac_seq.sv
// pe_mac_seq: sequential multiply-accumulate processing element.
//
// Computes a dot product of N_TERMS weight/input pairs, LANES products per
// cycle. It supports signed or unsigned operands, bias preload or
// continuation from the previous result, and requantisation to DATA_W with
// round-half-up right shift, optional ReLU and saturation. The block sits
// between the conv window buffer and the output-channel writeback.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         start pulse, accepted only while idle (busy=0)
//   acc_clear     1: accumulator starts from bias, 0: from current acc_out
//   signed_mode   1: two's-complement operands/accumulator, 0: unsigned
//   relu_en       clamp negative requantised result to 0 (signed mode only)
//   shift         requant right-shift amount
//   bias          accumulator preload used when acc_clear=1
//   weights_flat  term i at [i*DATA_W +: DATA_W]
//   inputs_flat   term i at [i*DATA_W +: DATA_W]
//   acc_out       raw accumulator result (wraps modulo 2^ACC_W)
//   q_out         requantised result
//   q_sat         q_out was clamped to the representable range
//   busy          operation in progress
//   done          one-cycle completion pulse
module pe_mac_seq #(
  parameter int N_TERMS = 27,
  parameter int DATA_W  = 8,
  parameter int LANES   = 9,
  parameter int ACC_W   = 24,
  parameter int SHIFT_W = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        acc_clear,
  input  logic                        signed_mode,
  input  logic                        relu_en,
  input  logic [SHIFT_W-1:0]          shift,
  input  logic [ACC_W-1:0]            bias,
  input  logic [N_TERMS*DATA_W-1:0]   weights_flat,
  input  logic [N_TERMS*DATA_W-1:0]   inputs_flat,
  output logic [ACC_W-1:0]            acc_out,
  output logic [DATA_W-1:0]           q_out,
  output logic                        q_sat,
  output logic                        busy,
  output logic                        done
);

  localparam int BEATS  = (N_TERMS + LANES - 1) / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Operands are zero-padded to a whole number of beats so that lanes
  // beyond N_TERMS in the final beat multiply zeros and contribute nothing.
  localparam int PAD_W  = BEATS * LANES * DATA_W;
  localparam int PROD_W = 2 * (DATA_W + 1);
  // One guard bit above the accumulator keeps the rounding add exact.
  localparam int R_W    = ACC_W + 1;

  localparam logic signed [R_W-1:0] S_MAX = R_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [R_W-1:0] S_MIN = ~S_MAX;
  localparam logic signed [R_W-1:0] U_MAX = R_W'((64'sd1 <<< DATA_W) - 64'sd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_FINISH
  } state_t;

  state_t state;
  state_t state_next;

  // Latched operation operands
  logic [PAD_W-1:0]   w_q;
  logic [PAD_W-1:0]   x_q;
  logic               signed_q;
  logic               relu_q;
  logic [SHIFT_W-1:0] shift_q;

  logic [ACC_W-1:0]   acc;
  logic [BEAT_W-1:0]  beat;
  logic               last_beat;
  logic               accept;

  // Lane datapath
  logic [DATA_W-1:0]        w_t;
  logic [DATA_W-1:0]        x_t;
  logic signed [DATA_W:0]   w_e;
  logic signed [DATA_W:0]   x_e;
  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         lane_sum;

  // Requant datapath
  logic signed [R_W-1:0]    acc_x;
  logic signed [R_W-1:0]    rnd;
  logic signed [R_W-1:0]    r;
  logic [DATA_W-1:0]        q_next;
  logic                     sat_next;

  assign accept    = (state == S_IDLE) && start;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written in a combinational block gets a default at
  // the top, so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_MAC;
      S_MAC:    if (last_beat) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Lane products for the current beat
  // ---------------------------------------------------------------------
  // NOTE: blocking assignments here are intentional: lane_sum is a running
  // combinational total built up across loop iterations, not state.
  always_comb begin
    lane_sum = '0;
    w_t      = '0;
    x_t      = '0;
    w_e      = '0;
    x_e      = '0;
    prod     = '0;
    for (int l = 0; l < LANES; l++) begin
      w_t  = w_q[(int'(beat) * LANES + l) * DATA_W +: DATA_W];
      x_t  = x_q[(int'(beat) * LANES + l) * DATA_W +: DATA_W];
      // One extra bit lets a single signed multiplier serve both modes:
      // sign-extend in signed mode, zero-extend otherwise.
      w_e  = {signed_q & w_t[DATA_W-1], w_t};
      x_e  = {signed_q & x_t[DATA_W-1], x_t};
      prod = w_e * x_e;
      // Sign-extending cast to accumulator width; sum wraps mod 2^ACC_W.
      lane_sum = lane_sum + ACC_W'(prod);
    end
  end

  // ---------------------------------------------------------------------
  // Requantisation of the final accumulator
  // ---------------------------------------------------------------------
  always_comb begin
    acc_x    = {signed_q & acc[ACC_W-1], acc};
    rnd      = acc_x;
    r        = acc_x;
    q_next   = '0;
    sat_next = 1'b0;

    if (shift_q == '0) begin
      r = acc_x;
    end else if (int'(shift_q) > ACC_W) begin
      // Rounding constant exceeds every accumulator magnitude: result is 0.
      r = '0;
    end else begin
      rnd = acc_x + (R_W'(1) << (shift_q - 1'b1));
      r   = signed_q ? (rnd >>> shift_q) : (rnd >> shift_q);
    end

    if (signed_q && relu_q && r[R_W-1]) begin
      q_next   = '0;
      sat_next = 1'b0;
    end else if (r > (signed_q ? S_MAX : U_MAX)) begin
      q_next   = signed_q ? DATA_W'(S_MAX) : DATA_W'(U_MAX);
      sat_next = 1'b1;
    end else if (signed_q && (r < S_MIN)) begin
      q_next   = DATA_W'(S_MIN);
      sat_next = 1'b1;
    end else begin
      q_next   = r[DATA_W-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------
  // NOTE: operand registers carry no reset; they are only read after an
  // accepted start has loaded them, so reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      w_q      <= PAD_W'(weights_flat);
      x_q      <= PAD_W'(inputs_flat);
      signed_q <= signed_mode;
      relu_q   <= relu_en;
      shift_q  <= shift;
    end
  end

  // ---------------------------------------------------------------------
  // Accumulator, beat counter and outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      beat    <= '0;
      acc_out <= '0;
      q_out   <= '0;
      q_sat   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc  <= acc_clear ? bias : acc_out;
            beat <= '0;
            busy <= 1'b1;
          end
        end
        S_MAC: begin
          acc  <= acc + lane_sum;
          beat <= beat + 1'b1;
        end
        S_FINISH: begin
          acc_out <= acc;
          q_out   <= q_next;
          q_sat   <= sat_next;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_seq.sv
// Testbench for pe_mac_seq: a default instance (27 terms, 9 lanes) and a
// 10-term, 4-lane instance with a partial last beat share all control
// inputs; the small instance sees the low 10 terms of the operand buses.
module tb_pe_mac_seq;

  localparam int N   = 27;
  localparam int DW  = 8;
  localparam int L   = 9;
  localparam int AW  = 24;
  localparam int SW  = 5;
  localparam int N2  = 10;
  localparam int L2  = 4;
  localparam int LAT = 4;  // ceil(terms/lanes) + 1 for both instances

  localparam longint AMASK = (64'sd1 <<< AW) - 64'sd1;
  localparam longint QMASK = (64'sd1 <<< DW) - 64'sd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              start;
  logic              acc_clear;
  logic              signed_mode;
  logic              relu_en;
  logic [SW-1:0]     shift;
  logic [AW-1:0]     bias;
  logic [N*DW-1:0]   w_flat;
  logic [N*DW-1:0]   x_flat;

  logic [AW-1:0]     acc_out,  acc_out2;
  logic [DW-1:0]     q_out,    q_out2;
  logic              q_sat,    q_sat2;
  logic              busy,     busy2;
  logic              done,     done2;

  pe_mac_seq #(.N_TERMS(N), .DATA_W(DW), .LANES(L), .ACC_W(AW), .SHIFT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_clear(acc_clear),
    .signed_mode(signed_mode), .relu_en(relu_en), .shift(shift), .bias(bias),
    .weights_flat(w_flat), .inputs_flat(x_flat),
    .acc_out(acc_out), .q_out(q_out), .q_sat(q_sat), .busy(busy), .done(done)
  );

  pe_mac_seq #(.N_TERMS(N2), .DATA_W(DW), .LANES(L2), .ACC_W(AW), .SHIFT_W(SW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_clear(acc_clear),
    .signed_mode(signed_mode), .relu_en(relu_en), .shift(shift), .bias(bias),
    .weights_flat(w_flat[N2*DW-1:0]), .inputs_flat(x_flat[N2*DW-1:0]),
    .acc_out(acc_out2), .q_out(q_out2), .q_sat(q_sat2), .busy(busy2), .done(done2)
  );

  int errors = 0;
  int checks = 0;

  // Current operand values (0 .. 2^DW-1), one per term
  int wv[N];
  int xv[N];

  // Expected previous acc_out of each instance, for acc_clear=0 runs
  longint prev1 = 0;
  longint prev2 = 0;

  // Outputs captured by run_op
  logic [AW-1:0] got_acc1, got_acc2;
  logic [DW-1:0] got_q1, got_q2;
  logic          got_sat1, got_sat2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint opv(input int v, input bit sgn);
    return (sgn && v >= (1 << (DW - 1))) ? longint'(v) - (64'sd1 <<< DW) : longint'(v);
  endfunction

  // Reference: exact integer dot product, wrapped to the accumulator width,
  // then round-half-up divide by 2^shift, ReLU and clamp.
  task automatic model(input int n, input bit clr, input bit sgn, input bit relu,
                       input int sh, input longint b, input longint prev,
                       output longint acc_e, output longint q_e, output longint sat_e);
    longint acc, a, r;
    acc = clr ? b : prev;
    for (int i = 0; i < n; i++) acc += opv(wv[i], sgn) * opv(xv[i], sgn);
    acc_e = acc & AMASK;
    a = (sgn && acc_e >= (64'sd1 <<< (AW - 1))) ? acc_e - (64'sd1 <<< AW) : acc_e;
    r = (sh > 0) ? ((a + (64'sd1 <<< (sh - 1))) >>> sh) : a;
    sat_e = 0;
    if (sgn && relu && r < 0) begin
      r = 0;
    end else if (sgn && r > (64'sd1 <<< (DW - 1)) - 1) begin
      r = (64'sd1 <<< (DW - 1)) - 1; sat_e = 1;
    end else if (sgn && r < -(64'sd1 <<< (DW - 1))) begin
      r = -(64'sd1 <<< (DW - 1)); sat_e = 1;
    end else if (!sgn && r > QMASK) begin
      r = QMASK; sat_e = 1;
    end
    q_e = r & QMASK;
  endtask

  // One operation: drive operands, pulse (or hold) start, measure latency
  // and busy width, capture outputs, confirm done is a single pulse.
  task automatic run_op(input bit clr, input bit sgn, input bit relu, input int sh,
                        input logic [AW-1:0] b, input bit hold);
    int e1, e2, busy_cyc, n;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      w_flat[i*DW +: DW] = DW'(wv[i]);
      x_flat[i*DW +: DW] = DW'(xv[i]);
    end
    acc_clear = clr; signed_mode = sgn; relu_en = relu; shift = SW'(sh); bias = b;
    start = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      // Start stays high and operands change while busy: both must be ignored.
      for (int i = 0; i < N; i++) begin
        w_flat[i*DW +: DW] = DW'($urandom);
        x_flat[i*DW +: DW] = DW'($urandom);
      end
      acc_clear = ~clr; signed_mode = ~sgn; relu_en = ~relu;
      shift = SW'($urandom); bias = AW'($urandom);
    end else begin
      start = 1'b0;
    end
    e1 = 0; e2 = 0; n = 0;
    busy_cyc = busy ? 1 : 0;
    while ((e1 == 0 || e2 == 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_cyc++;
      if (done && e1 == 0) e1 = n;
      if (done2 && e2 == 0) e2 = n;
      if (done) start = 1'b0;
    end
    start = 1'b0;
    check("latency", e1, LAT);
    check("latency_n10", e2, LAT);
    check("busy_cycles", busy_cyc, LAT);
    got_acc1 = acc_out;  got_q1 = q_out;  got_sat1 = q_sat;
    got_acc2 = acc_out2; got_q2 = q_out2; got_sat2 = q_sat2;
    @(posedge clk); #1;
    check("done_single_pulse", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  // Small instance is always checked against the model.
  task automatic check_n10(input bit clr, input bit sgn, input bit relu, input int sh,
                           input logic [AW-1:0] b);
    longint ea, eq, es;
    model(N2, clr, sgn, relu, sh, longint'(b), prev2, ea, eq, es);
    check("n10_acc", got_acc2, ea);
    check("n10_q", got_q2, eq);
    check("n10_sat", got_sat2, es);
    prev2 = ea;
  endtask

  typedef struct {
    bit            clr;
    bit            sgn;
    bit            relu;
    int            sh;
    logic [AW-1:0] b;
    int            wf;
    int            xf;
    bit            hold;
    logic [AW-1:0] e_acc;
    logic [DW-1:0] e_q;
    bit            e_sat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // {clr, sgn, relu, shift, bias, w, x, hold, acc, q, sat}
    vecs[0]  = '{1, 0, 0, 0,  24'd0,  1,    1,    0, 24'd27,       8'd27,  0};
    vecs[1]  = '{1, 1, 0, 0,  24'd0,  8'hFF, 2,   0, 24'hFFFFCA,   8'hCA,  0};
    vecs[2]  = '{1, 1, 1, 0,  24'd0,  8'hFF, 2,   0, 24'hFFFFCA,   8'h00,  0};
    vecs[3]  = '{1, 1, 0, 0,  24'd54, 8'hFF, 2,   0, 24'd0,        8'h00,  0};
    vecs[4]  = '{1, 1, 0, 0,  24'd0,  127,  127,  0, 24'd435483,   8'd127, 1};
    vecs[5]  = '{1, 1, 0, 12, 24'd0,  127,  127,  0, 24'd435483,   8'd106, 0};
    vecs[6]  = '{1, 1, 0, 0,  24'd0,  8'h80, 127, 0, 24'd16338304, 8'h80,  1};
    vecs[7]  = '{1, 0, 0, 0,  24'd0,  255,  255,  0, 24'd1755675,  8'hFF,  1};
    vecs[8]  = '{1, 0, 1, 1,  24'd0,  1,    1,    0, 24'd27,       8'd14,  0};
    vecs[9]  = '{1, 1, 0, 2,  24'd0,  8'hFF, 2,   0, 24'hFFFFCA,   8'hF3,  0};
    vecs[10] = '{1, 0, 0, 0,  24'd0,  1,    1,    0, 24'd27,       8'd27,  0};
    vecs[11] = '{0, 0, 0, 0,  24'd0,  1,    1,    1, 24'd54,       8'd54,  0};

    rst_n = 1'b0; start = 1'b0; acc_clear = 1'b0; signed_mode = 1'b0;
    relu_en = 1'b0; shift = '0; bias = '0; w_flat = '0; x_flat = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_acc_out", acc_out, 0);
    check("reset_q_out", q_out, 0);
    check("reset_q_sat", q_sat, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < N; i++) begin
        wv[i] = vecs[v].wf;
        xv[i] = vecs[v].xf;
      end
      run_op(vecs[v].clr, vecs[v].sgn, vecs[v].relu, vecs[v].sh, vecs[v].b, vecs[v].hold);
      check($sformatf("vec%0d_acc", v), got_acc1, vecs[v].e_acc);
      check($sformatf("vec%0d_q", v), got_q1, vecs[v].e_q);
      check($sformatf("vec%0d_sat", v), got_sat1, vecs[v].e_sat);
      prev1 = longint'(vecs[v].e_acc);
      check_n10(vecs[v].clr, vecs[v].sgn, vecs[v].relu, vecs[v].sh, vecs[v].b);
    end

    // Ramp weights: 10-term instance sums 1..10, 27-term sums 1..27
    for (int i = 0; i < N; i++) begin
      wv[i] = i + 1;
      xv[i] = 1;
    end
    run_op(1, 0, 0, 0, '0, 0);
    check("ramp_n10_acc", got_acc2, 55);
    check("ramp_n10_q", got_q2, 55);
    check("ramp_acc", got_acc1, 378);
    check("ramp_q_sat", got_sat1, 1);
    prev1 = 378;
    prev2 = 55;

    // Reset during MAC beat 1 abandons the operation
    for (int i = 0; i < N; i++) begin
      wv[i] = 1;
      xv[i] = 1;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      w_flat[i*DW +: DW] = DW'(wv[i]);
      x_flat[i*DW +: DW] = DW'(xv[i]);
    end
    acc_clear = 1'b1; signed_mode = 1'b0; relu_en = 1'b0; shift = '0; bias = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_acc_out", acc_out, 0);
    check("midreset_q_out", q_out, 0);
    check("midreset_n10_acc_out", acc_out2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dones;
      dones = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (done || done2) dones++;
      end
      check("midreset_no_done", dones, 0);
    end
    prev1 = 0;
    prev2 = 0;
    run_op(1, 0, 0, 0, '0, 0);
    check("post_reset_acc", got_acc1, 27);
    check("post_reset_q", got_q1, 27);
    prev1 = 27;
    check_n10(1, 0, 0, 0, '0);

    // Randomised operations against the reference model
    for (int t = 0; t < 40; t++) begin
      bit clr, sgn, relu, hold;
      int sh;
      logic [AW-1:0] b;
      longint ea, eq, es;
      for (int i = 0; i < N; i++) begin
        wv[i] = int'($urandom_range(0, (1 << DW) - 1));
        xv[i] = int'($urandom_range(0, (1 << DW) - 1));
      end
      clr  = ($urandom_range(0, 3) != 0);
      sgn  = 1'($urandom);
      relu = 1'($urandom);
      hold = ($urandom_range(0, 3) == 0);
      sh   = int'($urandom_range(0, (1 << SW) - 1));
      b    = AW'($urandom);
      model(N, clr, sgn, relu, sh, longint'(b), prev1, ea, eq, es);
      run_op(clr, sgn, relu, sh, b, hold);
      check($sformatf("rand%0d_acc", t), got_acc1, ea);
      check($sformatf("rand%0d_q", t), got_q1, eq);
      check($sformatf("rand%0d_sat", t), got_sat1, es);
      prev1 = ea;
      check_n10(clr, sgn, relu, sh, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
